xdma_dsc_byp_issuer: RTL and testbench
======================================

Name: xdma_dsc_byp_issuer

Overview:
Converts software-level DMA transfer requests into XDMA descriptor-bypass descriptors on the h2c/c2h dsc_byp channel-0 interface. Each request carries a host address, a card address, a length and a direction. Requests are split so that no descriptor crosses a MAX_CHUNK_BYTES boundary in host address space. The block sits between the DMA test/control logic and the XDMA core's descriptor bypass ports, and drives those ports directly.

Parameters:
MAX_CHUNK_BYTES, 4096, max descriptor length and host-address split boundary; power of two, 2..2^27
CTL_LAST, 16'h0013, dsc_byp_ctl value on the last descriptor of a request (stop | completed | EOP)
CTL_MID, 16'h0000, dsc_byp_ctl value on every non-last descriptor

Ports:
axi_aclk  in  1  clock, the XDMA user clock
axi_areset  in  1  asynchronous active-high reset
req_valid  in  1  transfer request valid
req_ready  out  1  block can accept a request
req_dir  in  1  0 = H2C, 1 = C2H
req_host_addr  in  64  host (PCIe) byte address
req_card_addr  in  64  card (AXI) byte address
req_len  in  28  byte count
h2c_dsc_byp_load  out  1  H2C descriptor strobe
h2c_dsc_byp_ready  in  1  H2C bypass ready
h2c_dsc_byp_src_addr  out  64  H2C source address (host side)
h2c_dsc_byp_dst_addr  out  64  H2C destination address (card side)
h2c_dsc_byp_len  out  28  H2C descriptor length
h2c_dsc_byp_ctl  out  16  H2C control field
c2h_dsc_byp_load  out  1  C2H descriptor strobe
c2h_dsc_byp_ready  in  1  C2H bypass ready
c2h_dsc_byp_src_addr  out  64  C2H source address (card side)
c2h_dsc_byp_dst_addr  out  64  C2H destination address (host side)
c2h_dsc_byp_len  out  28  C2H descriptor length
c2h_dsc_byp_ctl  out  16  C2H control field
busy  out  1  request in progress
done_valid  out  1  one-cycle pulse: all descriptors of the request are issued
done_dir  out  1  direction of the completed request; valid with done_valid
err_zero_len  out  1  one-cycle pulse: a zero-length request was rejected

Behaviour:
- Reset (async, active-high): state = IDLE; all registered outputs = 0. The load strobes are 0 because state != ISSUE. req_ready = 1 once reset is released.
- States: IDLE, CALC, ISSUE.
- IDLE:
  - req_ready = 1 (combinational on state).
  - On req_valid with req_len == 0: pulse err_zero_len for 1 cycle and stay in IDLE.
  - On req_valid with req_len != 0: latch dir, host_addr, card_addr and remaining = req_len; go to CALC.
- CALC (1 cycle):
  - to_boundary = MAX_CHUNK_BYTES - (host_addr mod MAX_CHUNK_BYTES).
  - chunk = min(remaining, to_boundary), registered.
  - last = (remaining == chunk), registered.
  - Drive the selected channel's fields, registered and held stable through ISSUE:
    - H2C: src = host_addr, dst = card_addr.
    - C2H: src = card_addr, dst = host_addr.
    - len = chunk; ctl = last ? CTL_LAST : CTL_MID.
  - Go to ISSUE.
- ISSUE:
  - load for the selected direction = (state == ISSUE) & that channel's ready. This is combinational from ready, so at most one load cycle per descriptor.
  - The other channel's load = 0; its fields hold their previous values.
  - Descriptor accepted in the cycle load = 1. On that cycle:
    - host_addr += chunk; card_addr += chunk (64-bit, wrap modulo 2^64).
    - remaining -= chunk.
    - If last: go to IDLE and pulse done_valid/done_dir on the next cycle. Otherwise go to CALC.
  - While ready is low: stay in ISSUE with all fields stable. There is no timeout.
- Throughput: one descriptor per 2 cycles when ready is held high. req_ready rises in the same cycle as done_valid.
- busy = (state != IDLE).
- Unused ready channel is ignored.
- Reset mid-request: the request is abandoned, no done pulse, and there is no partial-state replay after reset.
- req_valid outside IDLE is ignored; req_ready = 0 there.

Test Plan:
- H2C, host 0x1000, card 0x0, len 0x2000, ready = 1:
  - desc 1: src 0x1000, dst 0x0, len 0x1000, ctl 0x0000.
  - desc 2: src 0x2000, dst 0x1000, len 0x1000, ctl 0x0013.
  - Then done_valid with done_dir = 0; c2h load never asserted.
- C2H, host 0x0FF0, card 0x100, len 0x20:
  - desc 1: src 0x100, dst 0xFF0, len 0x10, ctl 0.
  - desc 2: src 0x110, dst 0x1000, len 0x10, ctl 0x0013.
  - Then done_dir = 1.
- req_len = 0 -> err_zero_len high for exactly 1 cycle; no load on either channel; req_ready stays 1; busy stays 0.
- H2C, len 0x100, h2c ready held low 10 cycles after CALC -> load = 0 and fields stable for all 10 cycles; req_ready = 0; single load on the cycle ready rises.
- H2C, host 0xFFF, len 1 -> one descriptor, len 1, ctl 0x0013; done 1 cycle after accept.
- H2C, host 0x0, len 0x3000; assert axi_areset after the first accept -> all outputs 0 asynchronously; no done pulse; after release, a new request completes normally.

Source files
------------

// File: rtl/xdma_dsc_byp_issuer.sv
// Splits software DMA requests into XDMA channel-0 descriptor-bypass descriptors,
// never letting a descriptor cross a MAX_CHUNK_BYTES boundary in host address space.
module xdma_dsc_byp_issuer #(
    parameter int unsigned MAX_CHUNK_BYTES = 4096,
    parameter logic [15:0] CTL_LAST        = 16'h0013,
    parameter logic [15:0] CTL_MID         = 16'h0000
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dir,
    input  logic [63:0] req_host_addr,
    input  logic [63:0] req_card_addr,
    input  logic [27:0] req_len,
    output logic        h2c_dsc_byp_load,
    input  logic        h2c_dsc_byp_ready,
    output logic [63:0] h2c_dsc_byp_src_addr,
    output logic [63:0] h2c_dsc_byp_dst_addr,
    output logic [27:0] h2c_dsc_byp_len,
    output logic [15:0] h2c_dsc_byp_ctl,
    output logic        c2h_dsc_byp_load,
    input  logic        c2h_dsc_byp_ready,
    output logic [63:0] c2h_dsc_byp_src_addr,
    output logic [63:0] c2h_dsc_byp_dst_addr,
    output logic [27:0] c2h_dsc_byp_len,
    output logic [15:0] c2h_dsc_byp_ctl,
    output logic        busy,
    output logic        done_valid,
    output logic        done_dir,
    output logic        err_zero_len
);

    localparam int unsigned OFF_W = (MAX_CHUNK_BYTES > 1) ? $clog2(MAX_CHUNK_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t      state, state_nxt;
    logic        dir;
    logic [63:0] host_addr;
    logic [63:0] card_addr;
    logic [27:0] remaining;
    logic [27:0] chunk;
    logic        last;

    logic [27:0] to_boundary;
    logic [27:0] chunk_c;
    logic        last_c;
    logic        accept;
    logic        req_take;

    // Bytes left before the host address reaches the next chunk boundary.
    assign to_boundary = 28'(MAX_CHUNK_BYTES) - 28'(host_addr[OFF_W-1:0]);
    assign chunk_c     = (remaining < to_boundary) ? remaining : to_boundary;
    assign last_c      = (remaining == chunk_c);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign req_take  = req_ready && req_valid && (req_len != '0);

    // Loads are combinational from ready so each descriptor strobes exactly once.
    assign h2c_dsc_byp_load = (state == ISSUE) && !dir && h2c_dsc_byp_ready;
    assign c2h_dsc_byp_load = (state == ISSUE) &&  dir && c2h_dsc_byp_ready;
    assign accept           = h2c_dsc_byp_load || c2h_dsc_byp_load;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_take) state_nxt = CALC;
            CALC:    state_nxt = ISSUE;
            ISSUE:   if (accept) state_nxt = last ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            dir                  <= 1'b0;
            host_addr            <= '0;
            card_addr            <= '0;
            remaining            <= '0;
            chunk                <= '0;
            last                 <= 1'b0;
            h2c_dsc_byp_src_addr <= '0;
            h2c_dsc_byp_dst_addr <= '0;
            h2c_dsc_byp_len      <= '0;
            h2c_dsc_byp_ctl      <= '0;
            c2h_dsc_byp_src_addr <= '0;
            c2h_dsc_byp_dst_addr <= '0;
            c2h_dsc_byp_len      <= '0;
            c2h_dsc_byp_ctl      <= '0;
            done_valid           <= 1'b0;
            done_dir             <= 1'b0;
            err_zero_len         <= 1'b0;
        end else begin
            done_valid   <= 1'b0;
            err_zero_len <= req_ready && req_valid && (req_len == '0);

            if (req_take) begin
                dir       <= req_dir;
                host_addr <= req_host_addr;
                card_addr <= req_card_addr;
                remaining <= req_len;
            end

            if (state == CALC) begin
                chunk <= chunk_c;
                last  <= last_c;
                if (!dir) begin
                    h2c_dsc_byp_src_addr <= host_addr;
                    h2c_dsc_byp_dst_addr <= card_addr;
                    h2c_dsc_byp_len      <= chunk_c;
                    h2c_dsc_byp_ctl      <= last_c ? CTL_LAST : CTL_MID;
                end else begin
                    c2h_dsc_byp_src_addr <= card_addr;
                    c2h_dsc_byp_dst_addr <= host_addr;
                    c2h_dsc_byp_len      <= chunk_c;
                    c2h_dsc_byp_ctl      <= last_c ? CTL_LAST : CTL_MID;
                end
            end

            if (accept) begin
                host_addr <= host_addr + 64'(chunk);
                card_addr <= card_addr + 64'(chunk);
                remaining <= remaining - chunk;
                if (last) begin
                    done_valid <= 1'b1;
                    done_dir   <= dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_xdma_dsc_byp_issuer.sv
// Bench for xdma_dsc_byp_issuer: directed table, hand-written corner sequences and
// randomized requests checked against a descriptor-list model.
module tb_xdma_dsc_byp_issuer;

    localparam int unsigned MAXB = 4096;

    logic        axi_aclk = 1'b0;
    logic        axi_areset;
    logic        req_valid, req_ready, req_dir;
    logic [63:0] req_host_addr, req_card_addr;
    logic [27:0] req_len;
    logic        h2c_dsc_byp_load, h2c_dsc_byp_ready;
    logic [63:0] h2c_dsc_byp_src_addr, h2c_dsc_byp_dst_addr;
    logic [27:0] h2c_dsc_byp_len;
    logic [15:0] h2c_dsc_byp_ctl;
    logic        c2h_dsc_byp_load, c2h_dsc_byp_ready;
    logic [63:0] c2h_dsc_byp_src_addr, c2h_dsc_byp_dst_addr;
    logic [27:0] c2h_dsc_byp_len;
    logic [15:0] c2h_dsc_byp_ctl;
    logic        busy, done_valid, done_dir, err_zero_len;

    xdma_dsc_byp_issuer #(.MAX_CHUNK_BYTES(MAXB)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_host_addr(req_host_addr), .req_card_addr(req_card_addr), .req_len(req_len),
        .h2c_dsc_byp_load(h2c_dsc_byp_load), .h2c_dsc_byp_ready(h2c_dsc_byp_ready),
        .h2c_dsc_byp_src_addr(h2c_dsc_byp_src_addr), .h2c_dsc_byp_dst_addr(h2c_dsc_byp_dst_addr),
        .h2c_dsc_byp_len(h2c_dsc_byp_len), .h2c_dsc_byp_ctl(h2c_dsc_byp_ctl),
        .c2h_dsc_byp_load(c2h_dsc_byp_load), .c2h_dsc_byp_ready(c2h_dsc_byp_ready),
        .c2h_dsc_byp_src_addr(c2h_dsc_byp_src_addr), .c2h_dsc_byp_dst_addr(c2h_dsc_byp_dst_addr),
        .c2h_dsc_byp_len(c2h_dsc_byp_len), .c2h_dsc_byp_ctl(c2h_dsc_byp_ctl),
        .busy(busy), .done_valid(done_valid), .done_dir(done_dir), .err_zero_len(err_zero_len)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic        ch;
        logic [63:0] src;
        logic [63:0] dst;
        logic [27:0] len;
        logic [15:0] ctl;
        int          cyc;
    } desc_t;

    typedef struct {
        logic        dir;
        logic [63:0] host;
        logic [63:0] card;
        logic [27:0] len;
        int          nd;
        logic [63:0] f_src, f_dst;
        logic [27:0] f_len;
        logic [63:0] l_src, l_dst;
        logic [27:0] l_len;
    } vec_t;

    desc_t cap[$];
    desc_t exp_q[$];
    vec_t  tv[6];
    int    n_vec = 0, n_bad = 0, cyc = 0, done_cyc = 0;
    logic  got_done, done_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
        cyc++;
    endtask

    // Issue one request and collect every descriptor strobe until done (bounded).
    task automatic run_req(input logic d, input logic [63:0] h, input logic [63:0] c,
                           input logic [27:0] l, input int pct);
        cap.delete();
        got_done = 1'b0;
        req_valid = 1'b1; req_dir = d; req_host_addr = h; req_card_addr = c; req_len = l;
        h2c_dsc_byp_ready = ($urandom_range(99) < pct);
        c2h_dsc_byp_ready = ($urandom_range(99) < pct);
        tick();
        req_valid = 1'b0;
        req_host_addr = {$urandom, $urandom};
        req_card_addr = {$urandom, $urandom};
        req_len = 28'($urandom);
        for (int i = 0; i < 3000 && !got_done; i++) begin
            h2c_dsc_byp_ready = ($urandom_range(99) < pct);
            c2h_dsc_byp_ready = ($urandom_range(99) < pct);
            @(negedge axi_aclk);
            if (h2c_dsc_byp_load)
                cap.push_back('{1'b0, h2c_dsc_byp_src_addr, h2c_dsc_byp_dst_addr,
                                h2c_dsc_byp_len, h2c_dsc_byp_ctl, cyc});
            if (c2h_dsc_byp_load)
                cap.push_back('{1'b1, c2h_dsc_byp_src_addr, c2h_dsc_byp_dst_addr,
                                c2h_dsc_byp_len, c2h_dsc_byp_ctl, cyc});
            if (done_valid) begin
                got_done = 1'b1;
                done_d   = done_dir;
                done_cyc = cyc;
            end
            tick();
        end
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Descriptor list derived straight from the splitting rule.
    task automatic build_model(input logic d, input logic [63:0] h, input logic [63:0] c,
                               input logic [27:0] l);
        logic [63:0] hh, cc, rem, bound, ch;
        exp_q.delete();
        hh = h; cc = c; rem = 64'(l);
        while (rem != 0) begin
            bound = 64'(MAXB) - (hh % 64'(MAXB));
            ch    = (rem < bound) ? rem : bound;
            exp_q.push_back('{d, d ? cc : hh, d ? hh : cc, 28'(ch),
                              (rem == ch) ? 16'h0013 : 16'h0000, 0});
            hh += ch; cc += ch; rem -= ch;
        end
    endtask

    initial begin
        logic        found;
        logic        rd;
        logic [63:0] rh, rc;
        logic [27:0] rl;
        int          n;

        tv[0] = '{1'b0, 64'h1000, 64'h0, 28'h2000, 2,
                  64'h1000, 64'h0, 28'h1000, 64'h2000, 64'h1000, 28'h1000};
        tv[1] = '{1'b1, 64'h0FF0, 64'h100, 28'h20, 2,
                  64'h100, 64'hFF0, 28'h10, 64'h110, 64'h1000, 28'h10};
        tv[2] = '{1'b0, 64'h0FFF, 64'h40, 28'h1, 1,
                  64'hFFF, 64'h40, 28'h1, 64'hFFF, 64'h40, 28'h1};
        tv[3] = '{1'b1, 64'h0, 64'h8000, 28'h1000, 1,
                  64'h8000, 64'h0, 28'h1000, 64'h8000, 64'h0, 28'h1000};
        tv[4] = '{1'b0, 64'h800, 64'h10, 28'h1801, 3,
                  64'h800, 64'h10, 28'h800, 64'h2000, 64'h1810, 28'h1};
        tv[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_F800, 64'h0, 28'h1000, 2,
                  64'hFFFF_FFFF_FFFF_F800, 64'h0, 28'h800, 64'h0, 64'h800, 28'h800};

        axi_areset = 1'b1;
        req_valid = 1'b0; req_dir = 1'b0; req_host_addr = '0; req_card_addr = '0; req_len = '0;
        h2c_dsc_byp_ready = 1'b1; c2h_dsc_byp_ready = 1'b1;
        tick(); tick();
        @(negedge axi_aclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_loads", {62'd0, h2c_dsc_byp_load, c2h_dsc_byp_load}, 64'd0);
        chk("rst_done", 64'(done_valid), 64'd0);
        chk("rst_err", 64'(err_zero_len), 64'd0);
        chk("rst_h2c_len", 64'(h2c_dsc_byp_len), 64'd0);
        tick();
        axi_areset = 1'b0;
        @(negedge axi_aclk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        tick();

        // Directed table with ready held high
        foreach (tv[k]) begin
            run_req(tv[k].dir, tv[k].host, tv[k].card, tv[k].len, 100);
            n = cap.size();
            chk($sformatf("tv%0d_ndesc", k), 64'(n), 64'(tv[k].nd));
            if (n > 0) begin
                chk($sformatf("tv%0d_f_src", k), cap[0].src, tv[k].f_src);
                chk($sformatf("tv%0d_f_dst", k), cap[0].dst, tv[k].f_dst);
                chk($sformatf("tv%0d_f_len", k), 64'(cap[0].len), 64'(tv[k].f_len));
                chk($sformatf("tv%0d_l_src", k), cap[n-1].src, tv[k].l_src);
                chk($sformatf("tv%0d_l_dst", k), cap[n-1].dst, tv[k].l_dst);
                chk($sformatf("tv%0d_l_len", k), 64'(cap[n-1].len), 64'(tv[k].l_len));
                for (int i = 0; i < n; i++) begin
                    chk($sformatf("tv%0d_ch%0d", k, i), 64'(cap[i].ch), 64'(tv[k].dir));
                    chk($sformatf("tv%0d_ctl%0d", k, i), 64'(cap[i].ctl),
                        (i == n - 1) ? 64'h13 : 64'h0);
                    if (i > 0)
                        chk($sformatf("tv%0d_gap%0d", k, i), 64'(cap[i].cyc - cap[i-1].cyc), 64'd2);
                end
                if (got_done) begin
                    chk($sformatf("tv%0d_done_lat", k), 64'(done_cyc - cap[n-1].cyc), 64'd1);
                    chk($sformatf("tv%0d_done_dir", k), 64'(done_d), 64'(tv[k].dir));
                end
            end
            @(negedge axi_aclk);
            chk($sformatf("tv%0d_done_pulse", k), 64'(done_valid), 64'd0);
            chk($sformatf("tv%0d_idle", k), 64'(req_ready), 64'd1);
            tick();
        end

        // Zero-length request
        req_valid = 1'b1; req_dir = 1'b0; req_len = '0; req_host_addr = 64'h40;
        @(negedge axi_aclk);
        chk("zl_busy0", 64'(busy), 64'd0);
        tick();
        req_valid = 1'b0;
        @(negedge axi_aclk);
        chk("zl_err", 64'(err_zero_len), 64'd1);
        chk("zl_busy", 64'(busy), 64'd0);
        chk("zl_req_ready", 64'(req_ready), 64'd1);
        chk("zl_loads", {62'd0, h2c_dsc_byp_load, c2h_dsc_byp_load}, 64'd0);
        tick();
        @(negedge axi_aclk);
        chk("zl_err_pulse", 64'(err_zero_len), 64'd0);
        chk("zl_busy2", 64'(busy), 64'd0);
        tick();

        // Back-pressure: h2c ready low for 10 cycles in ISSUE; c2h ready must be ignored
        h2c_dsc_byp_ready = 1'b0; c2h_dsc_byp_ready = 1'b1;
        req_valid = 1'b1; req_dir = 1'b0; req_host_addr = 64'h0; req_card_addr = 64'h200;
        req_len = 28'h100;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge axi_aclk);
            chk("bp_load", {62'd0, h2c_dsc_byp_load, c2h_dsc_byp_load}, 64'd0);
            chk("bp_src", h2c_dsc_byp_src_addr, 64'h0);
            chk("bp_dst", h2c_dsc_byp_dst_addr, 64'h200);
            chk("bp_len", 64'(h2c_dsc_byp_len), 64'h100);
            chk("bp_ctl", 64'(h2c_dsc_byp_ctl), 64'h13);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        h2c_dsc_byp_ready = 1'b1;
        @(negedge axi_aclk);
        chk("bp_load_rise", 64'(h2c_dsc_byp_load), 64'd1);
        tick();
        @(negedge axi_aclk);
        chk("bp_done", 64'(done_valid), 64'd1);
        chk("bp_done_dir", 64'(done_dir), 64'd0);
        chk("bp_req_ready_done", 64'(req_ready), 64'd1);
        chk("bp_single_load", 64'(h2c_dsc_byp_load), 64'd0);
        tick();

        // Reset in the middle of a multi-descriptor request
        req_valid = 1'b1; req_dir = 1'b0; req_host_addr = 64'h0; req_card_addr = 64'h5000;
        req_len = 28'h3000;
        tick();
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge axi_aclk);
            if (h2c_dsc_byp_load) found = 1'b1;
            else tick();
        end
        chk("mr_first_load", 64'(found), 64'd1);
        chk("mr_pre_dst", h2c_dsc_byp_dst_addr, 64'h5000);
        tick();
        axi_areset = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_loads", {62'd0, h2c_dsc_byp_load, c2h_dsc_byp_load}, 64'd0);
        chk("mr_dst", h2c_dsc_byp_dst_addr, 64'h0);
        chk("mr_len", 64'(h2c_dsc_byp_len), 64'h0);
        chk("mr_ctl", 64'(h2c_dsc_byp_ctl), 64'h0);
        chk("mr_done", 64'(done_valid), 64'd0);
        tick(); tick();
        axi_areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_aclk);
            chk("mr_no_done", 64'(done_valid), 64'd0);
            chk("mr_idle", 64'(busy), 64'd0);
            tick();
        end
        run_req(1'b0, 64'h100, 64'h0, 28'h10, 100);
        chk("mr_after_ndesc", 64'(cap.size()), 64'd1);
        if (cap.size() == 1) begin
            chk("mr_after_len", 64'(cap[0].len), 64'h10);
            chk("mr_after_ctl", 64'(cap[0].ctl), 64'h13);
        end

        // Randomized requests with random back-pressure against the model
        for (int r = 0; r < 25; r++) begin
            rd = 1'($urandom);
            rh = {$urandom, $urandom};
            if ($urandom_range(1) == 1) rh[11:0] = 12'hFFF - 12'($urandom_range(15));
            rc = {$urandom, $urandom};
            rl = 28'($urandom_range(1, 28'h3000));
            build_model(rd, rh, rc, rl);
            run_req(rd, rh, rc, rl, $urandom_range(30, 100));
            chk($sformatf("rnd%0d_ndesc", r), 64'(cap.size()), 64'(exp_q.size()));
            for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
                chk($sformatf("rnd%0d_ch%0d", r, i), 64'(cap[i].ch), 64'(exp_q[i].ch));
                chk($sformatf("rnd%0d_src%0d", r, i), cap[i].src, exp_q[i].src);
                chk($sformatf("rnd%0d_dst%0d", r, i), cap[i].dst, exp_q[i].dst);
                chk($sformatf("rnd%0d_len%0d", r, i), 64'(cap[i].len), 64'(exp_q[i].len));
                chk($sformatf("rnd%0d_ctl%0d", r, i), 64'(cap[i].ctl), 64'(exp_q[i].ctl));
            end
            if (got_done) chk($sformatf("rnd%0d_done_dir", r), 64'(done_d), 64'(rd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
